led_pattern_ctrl: RTL and testbench



---
 rtl/led_pkg.sv | 39 +++
 rtl/led_prescaler.sv | 32 +++
 rtl/led_pattern_ctrl.sv | 113 +++++++++++
 tb/tb_led_pattern_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and start patterns for the LED ring sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        ModeRotL   = 2'd0,
        ModeRotR   = 2'd1,
        ModeBounce = 2'd2,
        ModeBlink  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StApply
    } state_t;

    typedef enum logic {
        DirLeft,
        DirRight
    } dir_t;

    localparam int unsigned RingW = 4;

    localparam logic [RingW-1:0] StartRotL   = 4'b0001;
    localparam logic [RingW-1:0] StartRotR   = 4'b1000;
    localparam logic [RingW-1:0] StartBounce = 4'b0001;
    localparam logic [RingW-1:0] StartBlink  = 4'b1111;

    function automatic logic [RingW-1:0] start_pattern(input mode_t m);
        case (m)
            ModeRotL:   return StartRotL;
            ModeRotR:   return StartRotR;
            ModeBounce: return StartBounce;
            ModeBlink:  return StartBlink;
            default:    return StartRotL;
        endcase
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Programmable step tick: one-cycle pulse every TICK_DIV << rate enabled cycles.
module led_prescaler #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] rate,
    output logic       step
);

    // Sized for the longest period (rate 3) so the terminal count never overflows.
    localparam int unsigned CntW = $clog2(TICK_DIV * 8);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] term;

    assign term = CntW'((TICK_DIV << rate) - 1);
    assign step = en && (cnt_q == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= step ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED ring pattern sequencer: command handshake, mode FSM and pattern stepping.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned N_LEDS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [1:0]        cmd_rate,
    input  logic              pause,
    output logic [N_LEDS-1:0] led,
    output logic              led_center
);

    localparam logic [N_LEDS-1:0] LedFirst = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] LedLast  = N_LEDS'(1) << (N_LEDS - 1);

    state_t            state_q;
    mode_t             mode_q;
    logic [1:0]        rate_q;
    dir_t              dir_q;
    logic [N_LEDS-1:0] led_q;
    logic              ready_q;
    logic              center_q;

    logic              step;
    logic [N_LEDS-1:0] led_stepped;
    dir_t              dir_stepped;

    led_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == StRun && !pause),
        .clr   (state_q != StRun),
        .rate  (rate_q),
        .step  (step)
    );

    always_comb begin
        led_stepped = led_q;
        dir_stepped = dir_q;
        case (mode_q)
            ModeRotL:  led_stepped = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
            ModeRotR:  led_stepped = {led_q[0], led_q[N_LEDS-1:1]};
            ModeBounce: begin
                led_stepped = (dir_q == DirLeft) ? (led_q << 1) : (led_q >> 1);
                // Turn around on reaching an end so each end LED is lit for one step only.
                if (led_stepped == LedLast) begin
                    dir_stepped = DirRight;
                end else if (led_stepped == LedFirst) begin
                    dir_stepped = DirLeft;
                end
            end
            ModeBlink: led_stepped = ~led_q;
            default:   led_stepped = led_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            mode_q   <= ModeRotL;
            rate_q   <= 2'd0;
            dir_q    <= DirLeft;
            led_q    <= '0;
            ready_q  <= 1'b0;
            center_q <= 1'b0;
        end else begin
            center_q <= (state_q == StRun) && !pause;
            case (state_q)
                StInit: begin
                    led_q   <= N_LEDS'(start_pattern(mode_q));
                    dir_q   <= DirLeft;
                    ready_q <= 1'b1;
                    state_q <= StRun;
                end
                StRun: begin
                    // An accepted command pre-empts a coincident step.
                    if (cmd_valid && ready_q) begin
                        mode_q  <= mode_t'(cmd_mode);
                        rate_q  <= cmd_rate;
                        ready_q <= 1'b0;
                        state_q <= StApply;
                    end else if (step) begin
                        led_q <= led_stepped;
                        dir_q <= dir_stepped;
                    end
                end
                StApply: begin
                    led_q   <= N_LEDS'(start_pattern(mode_q));
                    dir_q   <= DirLeft;
                    ready_q <= 1'b1;
                    state_q <= StRun;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= StInit;
                end
            endcase
        end
    end

    assign led        = led_q;
    assign led_center = center_q;
    assign cmd_ready  = ready_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Table-driven bench for led_pattern_ctrl with TICK_DIV=4 and a queue scoreboard.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'd0;
    logic [1:0] cmd_rate = 2'd0;
    logic       pause = 1'b0;
    logic [3:0] led;
    logic       led_center;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       v;
        logic [1:0] m;
        logic [1:0] r;
        logic       p;
        int         n;
        logic [3:0] led;
        logic       ctr;
        logic       rdy;
    } vec_t;

    typedef struct {
        logic [3:0] led;
        logic       ctr;
        logic       rdy;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   row = 0;

    led_pattern_ctrl #(
        .TICK_DIV (4),
        .N_LEDS   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_rate   (cmd_rate),
        .pause      (pause),
        .led        (led),
        .led_center (led_center)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    // Called at a falling edge; leaves at the next falling edge after the compare.
    task automatic apply(input vec_t v);
        exp_t e;
        cmd_valid = v.v;
        cmd_mode  = v.m;
        cmd_rate  = v.r;
        pause     = v.p;
        sb.push_back('{v.led, v.ctr, v.rdy, row});
        repeat (v.n) @(posedge clk);
        #1;
        e = sb.pop_front();
        check("led", e.idx, {28'd0, led}, {28'd0, e.led});
        check("led_center", e.idx, {31'd0, led_center}, {31'd0, e.ctr});
        check("cmd_ready", e.idx, {31'd0, cmd_ready}, {31'd0, e.rdy});
        row++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input int idx);
        check("reset_led", idx, {28'd0, led}, 32'd0);
        check("reset_center", idx, {31'd0, led_center}, 32'd0);
        check("reset_ready", idx, {31'd0, cmd_ready}, 32'd0);
    endtask

    initial begin
        // ROT_L from reset
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 3, 4'b0001, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0010, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b0100, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b1000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b0001, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 2, 4'b0001, 1'b1, 1'b1});
        // ROT_R accepted mid-count
        vecs.push_back('{1'b1, 2'd1, 2'd0, 1'b0, 1, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b1000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 3, 4'b1000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0100, 1'b1, 1'b1});
        // BOUNCE
        vecs.push_back('{1'b1, 2'd2, 2'd0, 1'b0, 1, 4'b0100, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b0010, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b0100, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b1000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b0100, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b0010, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b0001, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 4, 4'b0010, 1'b1, 1'b1});
        // BLINK at rate 2
        vecs.push_back('{1'b1, 2'd3, 2'd2, 1'b0, 1, 4'b0010, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b1111, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 15, 4'b1111, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 16, 4'b1111, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 16, 4'b0000, 1'b1, 1'b1});
        // Pause for 10 cycles mid-period
        vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 1, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 2, 4'b0001, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b1, 1, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b1, 9, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0001, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0010, 1'b1, 1'b1});
        // Command on the exact step cycle
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 3, 4'b0010, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 2'd1, 2'd0, 1'b0, 1, 4'b0010, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b1000, 1'b0, 1'b1});
        // Command while paused
        vecs.push_back('{1'b1, 2'd2, 2'd0, 1'b1, 1, 4'b1000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b1, 1, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b1, 5, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 3, 4'b0001, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0010, 1'b1, 1'b1});
        // Valid held through APPLY, re-accepted on first RUN cycle
        vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 1, 4'b0010, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 1, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 1, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 3, 4'b0001, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0010, 1'b1, 1'b1});
        // Same mode re-sent restarts the pattern
        vecs.push_back('{1'b1, 2'd0, 2'd0, 1'b0, 1, 4'b0010, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0001, 1'b0, 1'b1});
        // ROT_R at rate 1 so the reset below must restore mode and rate
        vecs.push_back('{1'b1, 2'd1, 2'd1, 1'b0, 1, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b1000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 7, 4'b1000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0100, 1'b1, 1'b1});

        @(negedge clk);
        check_reset_outputs(-1);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset mid-run: outputs clear without a clock edge.
        rst_n = 1'b0;
        #1;
        check_reset_outputs(row);
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs(row);
        rst_n = 1'b1;
        apply('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0001, 1'b0, 1'b1});
        apply('{1'b0, 2'd0, 2'd0, 1'b0, 3, 4'b0001, 1'b1, 1'b1});
        apply('{1'b0, 2'd0, 2'd0, 1'b0, 1, 4'b0010, 1'b1, 1'b1});

        check("scoreboard_empty", row, sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
